// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, optional parity bit,
// and a stop bit of SB_TICK ticks, all paced by a 16x oversampling S_TICK.
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            i_CLK,
  input  logic            i_RST,
  input  logic            S_TICK,
  input  logic            TX_START,
  input  logic [DBIT-1:0] DIN,
  output logic            TX,
  output logic            TX_BUSY,
  output logic            TX_DONE
);

  localparam int S_W = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int N_W = $clog2(DBIT);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [S_W-1:0]  s, s_next;
  logic [N_W-1:0]  n, n_next;
  logic [DBIT-1:0] shreg, shreg_next;
  logic            par, par_next;
  logic            tx_reg, tx_next;
  logic            done_reg, done_next;

  function automatic logic parity_of(input logic [DBIT-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      tx_reg   <= 1'b1;
      done_reg <= 1'b0;
    end else begin
      state    <= state_next;
      s        <= s_next;
      n        <= n_next;
      shreg    <= shreg_next;
      par      <= par_next;
      tx_reg   <= tx_next;
      done_reg <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    shreg_next = shreg;
    par_next   = par;
    done_next  = 1'b0;
    tx_next    = 1'b1;
    case (state)
      IDLE: begin
        if (TX_START) begin
          state_next = START;
          s_next     = '0;
          n_next     = '0;
          shreg_next = DIN;
          // Parity is taken from the whole word before it is shifted out.
          par_next   = parity_of(DIN);
        end
      end
      START: begin
        if (S_TICK) begin
          if (s == S_W'(15)) begin
            s_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (S_TICK) begin
          if (s == S_W'(15)) begin
            s_next     = '0;
            shreg_next = shreg >> 1;
            if (n == N_W'(DBIT - 1)) begin
              state_next = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (S_TICK) begin
          if (s == S_W'(15)) begin
            s_next     = '0;
            state_next = STOP;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (S_TICK) begin
          if (s == S_W'(SB_TICK - 1)) begin
            s_next     = '0;
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Line level is registered from the state being entered, so TX never
    // sees a combinational path from the inputs.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      PARITY:  tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  assign TX      = tx_reg;
  assign TX_BUSY = (state != IDLE);
  assign TX_DONE = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three parameterisations driven in parallel, checked every
// cycle against a tick-count frame model, plus directed literal expectations.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx [3];
  logic       busy [3];
  logic       done [3];

  int total = 0;
  int bad = 0;
  int tick_mode = 0;

  localparam int DB [3] = '{8, 8, 7};
  localparam int PE [3] = '{0, 1, 1};
  localparam int PO [3] = '{0, 0, 1};
  localparam int SB [3] = '{16, 16, 32};

  logic [7:0] lb_bytes [4] = '{8'hAB, 8'hF7, 8'h96, 8'h3D};

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .i_CLK(clk), .i_RST(rst), .S_TICK(tick), .TX_START(start), .DIN(din),
    .TX(tx[0]), .TX_BUSY(busy[0]), .TX_DONE(done[0]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .i_CLK(clk), .i_RST(rst), .S_TICK(tick), .TX_START(start), .DIN(din),
    .TX(tx[1]), .TX_BUSY(busy[1]), .TX_DONE(done[1]));
  uart_tx #(.DBIT(7), .SB_TICK(32), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
    .i_CLK(clk), .i_RST(rst), .S_TICK(tick), .TX_START(start), .DIN(din[6:0]),
    .TX(tx[2]), .TX_BUSY(busy[2]), .TX_DONE(done[2]));

  always #5 clk = ~clk;

  // Tick source: every third clock, or random density in mode 1.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      if (tick_mode == 0) begin
        tick = (ph == 2);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        tick = ($urandom_range(2) == 0);
      end
    end
  end

  // Frame model: a frame is a tick index k into a bit list of 16-tick slots.
  bit         m_act [3];
  bit         m_done [3];
  int         m_k [3];
  logic [7:0] m_d [3];

  function automatic int frame_len(input int i);
    return (1 + DB[i] + PE[i]) * 16 + SB[i];
  endfunction

  function automatic logic exp_tx(input int i);
    int k;
    if (!m_act[i]) return 1'b1;
    k = m_k[i];
    if (k < 16) return 1'b0;
    if (k < 16 * (1 + DB[i])) return m_d[i][(k - 16) / 16];
    if (PE[i] != 0 && k < 16 * (2 + DB[i])) return (^m_d[i]) ^ (PO[i] != 0);
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_act[i] = 0; m_done[i] = 0; m_k[i] = 0; m_d[i] = '0;
      end else begin
        m_done[i] = 0;
        if (!m_act[i]) begin
          if (start) begin
            m_act[i] = 1;
            m_k[i] = 0;
            m_d[i] = din & 8'((1 << DB[i]) - 1);
          end
        end else if (tick) begin
          m_k[i] = m_k[i] + 1;
          if (m_k[i] == frame_len(i)) begin
            m_act[i] = 0;
            m_done[i] = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_tx%0d", i), 32'(tx[i]), 32'(exp_tx(i)));
      chk($sformatf("model_busy%0d", i), 32'(busy[i]), 32'(m_act[i]));
      chk($sformatf("model_done%0d", i), 32'(done[i]), 32'(m_done[i]));
    end
  end

  task automatic step(input int cnt);
    repeat (cnt) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy[0] | busy[1] | busy[2]) && g < 3000) begin
      step(1);
      g++;
    end
    chk("idle_bound", 32'(g < 3000), 32'd1);
    step(2);
  endtask

  task automatic send(input logic [7:0] b);
    din = b;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  // Samples DUT A mid-bit for ten bits and counts TX_DONE pulses; optional
  // TX_START pulses with DIN=FF at cycles p1/p2 after acceptance.
  task automatic sample_frame(input int ncyc, input int p1, input int p2,
                              output logic [9:0] bits, output int dcnt, output int dc);
    bits = '0;
    dcnt = 0;
    dc = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (c >= 24 && (c - 24) % 48 == 0 && (c - 24) / 48 < 10) bits[(c - 24) / 48] = tx[0];
      if (done[0] === 1'b1) begin
        dcnt++;
        if (dc < 0) dc = c;
      end
      if (c == p1 || c == p2) begin
        start = 1'b1;
        din = 8'hFF;
      end else begin
        start = 1'b0;
      end
      step(1);
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    logic [7:0] rb;
    int dcnt, dc, g, dcb, dcc;

    step(3);
    chk("rst_tx", 32'(tx[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    rst = 1'b0;
    step(2);

    // Basic frame A5
    send(8'hA5);
    sample_frame(520, -1, -1, bits, dcnt, dc);
    chk("a5_bits", 32'(bits), 32'(10'b1101001010));
    chk("a5_done_cnt", dcnt, 1);
    chk("a5_done_lat", 32'(dc >= 477 && dc <= 483), 32'd1);
    wait_idle();

    // Back-to-back with TX_START held high
    din = lb_bytes[0];
    start = 1'b1;
    for (int f = 0; f < 4; f++) begin
      g = 0;
      while (tx[0] !== 1'b0 && g < 1000) begin step(1); g++; end
      chk("lb_start_bound", 32'(g < 1000), 32'd1);
      if (f < 3) din = lb_bytes[f + 1];
      else start = 1'b0;
      step(72);
      rb[0] = tx[0];
      for (int j = 1; j < 8; j++) begin
        step(48);
        rb[j] = tx[0];
      end
      chk($sformatf("lb_byte%0d", f), 32'(rb), 32'(lb_bytes[f]));
      g = 0;
      while (done[0] !== 1'b1 && g < 300) begin step(1); g++; end
      chk("lb_done_bound", 32'(g < 300), 32'd1);
      chk("lb_idle_level", 32'(tx[0]), 32'd1);
      step(1);
      if (f < 3) chk("lb_gap", 32'(tx[0]), 32'd0);
    end
    wait_idle();

    // Parity: B even parity of 07 = 1, C odd parity of 07 = 0; C has 2 stop bits
    send(8'h07);
    dcb = -1;
    dcc = -1;
    for (int c = 0; c < 600; c++) begin
      if (c == 408) chk("par_odd_c", 32'(tx[2]), 32'd0);
      if (c == 456) begin
        chk("par_even_b", 32'(tx[1]), 32'd1);
        chk("stop_c_early", 32'(tx[2]), 32'd1);
      end
      if (c == 520) chk("stop_c_late", 32'(tx[2]), 32'd1);
      if (done[1] === 1'b1 && dcb < 0) dcb = c;
      if (done[2] === 1'b1 && dcc < 0) dcc = c;
      step(1);
    end
    chk("par_len_b", 32'(dcb >= 525 && dcb <= 531), 32'd1);
    chk("stop_len_c", 32'(dcc >= 525 && dcc <= 531), 32'd1);
    wait_idle();

    // Busy protection
    send(8'h3C);
    sample_frame(520, 120, 450, bits, dcnt, dc);
    chk("busy_bits", 32'(bits), 32'(10'b1001111000));
    chk("busy_done_cnt", dcnt, 1);
    wait_idle();

    // Reset during data bit 3 of 00
    send(8'h00);
    step(216);
    chk("pre_rst_tx", 32'(tx[0]), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", 32'(tx[0]), 32'd1);
    chk("async_rst_busy", 32'(busy[0]), 32'd0);
    chk("async_rst_busy_c", 32'(busy[2]), 32'd0);
    step(2);
    rst = 1'b0;
    step(2);
    send(8'h55);
    sample_frame(520, -1, -1, bits, dcnt, dc);
    chk("post_rst_bits", 32'(bits), 32'(10'b1010101010));
    chk("post_rst_done_cnt", dcnt, 1);
    wait_idle();

    // Randomized traffic, tick density and resets
    for (int it = 0; it < 40; it++) begin
      tick_mode = int'($urandom_range(1));
      repeat ($urandom_range(20, 400)) begin
        start = ($urandom_range(7) == 0);
        din = 8'($urandom);
        step(1);
      end
      if ($urandom_range(9) == 0) begin
        rst = 1'b1;
        step(2);
        start = ($urandom_range(1) == 0);
        rst = 1'b0;
        step(1);
      end
    end
    start = 1'b0;
    tick_mode = 0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
